// File: rtl/radix_digit_converter_if.sv
// Handshake and result bundle between the processor side and the digit converter.
// The master drives a conversion request; the slave (converter) returns published results.
interface radix_digit_converter_if;
    logic        start;
    logic [31:0] value;
    logic [3:0]  radix;
    logic        busy;
    logic        done;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        neg;
    logic        ovf;
    logic        valid;

    modport master (
        output start, value, radix,
        input  busy, done, digits, blank, neg, ovf, valid
    );

    modport slave (
        input  start, value, radix,
        output busy, done, digits, blank, neg, ovf, valid
    );
endinterface

// File: rtl/radix_digit_converter.sv
// Converts a signed 32-bit word into eight digits of a base 1..16 by restoring division,
// one quotient bit per cycle, publishing digits/sign/blanking/overflow atomically.
module radix_digit_converter (
    input  logic                    clk,
    input  logic                    rst,
    radix_digit_converter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_DIV,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] dividend;
    logic [31:0] work;
    logic [4:0]  rem;
    logic [4:0]  base;
    logic [4:0]  bit_cnt;
    logic [2:0]  idx;
    logic        sign;

    logic [31:0] digits_r;
    logic [7:0]  blank_r;
    logic        busy_r;
    logic        done_r;
    logic        valid_r;
    logic        neg_r;
    logic        ovf_r;

    logic [4:0]  shifted;
    logic        fits;

    // Dividend and quotient share one register: the MSB leaves as the quotient bit enters.
    assign shifted = {rem[3:0], dividend[31]};
    assign fits    = (shifted >= base);

    function automatic logic [7:0] compute_blank(input logic [31:0] d);
        logic [7:0] b;
        logic       all_zero;
        b        = 8'h00;
        all_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (d[i*4 +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
            b[i] = all_zero;
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            dividend <= 32'd0;
            work     <= 32'd0;
            rem      <= 5'd0;
            base     <= 5'd0;
            bit_cnt  <= 5'd0;
            idx      <= 3'd0;
            sign     <= 1'b0;
            digits_r <= 32'd0;
            blank_r  <= 8'hFE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dividend <= bus.value;
                        base     <= (bus.radix == 4'd0) ? 5'd16 : {1'b0, bus.radix};
                        busy_r   <= 1'b1;
                        state    <= S_ABS;
                    end
                end
                S_ABS: begin
                    sign     <= dividend[31];
                    dividend <= dividend[31] ? (~dividend + 32'd1) : dividend;
                    rem      <= 5'd0;
                    bit_cnt  <= 5'd0;
                    idx      <= 3'd0;
                    work     <= 32'd0;
                    state    <= S_DIV;
                end
                S_DIV: begin
                    rem      <= fits ? (shifted - base) : shifted;
                    dividend <= {dividend[30:0], fits};
                    bit_cnt  <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    work[{idx, 2'b00} +: 4] <= rem[3:0];
                    rem   <= 5'd0;
                    idx   <= idx + 3'd1;
                    state <= (idx == 3'd7) ? S_DONE : S_DIV;
                end
                S_DONE: begin
                    // Whatever quotient is left after eight digits means the value did not fit.
                    digits_r <= work;
                    blank_r  <= compute_blank(work);
                    neg_r    <= sign;
                    ovf_r    <= (dividend != 32'd0);
                    valid_r  <= 1'b1;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.digits = digits_r;
    assign bus.blank  = blank_r;
    assign bus.neg    = neg_r;
    assign bus.ovf    = ovf_r;
    assign bus.valid  = valid_r;

endmodule

// File: tb/tb_radix_digit_converter.sv
// Self-checking bench for radix_digit_converter: directed and random conversions
// compared against an arithmetic reference model of base conversion.
module tb_radix_digit_converter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_pulses;
    int   unstable;
    int   overlap;

    logic [31:0] last_digits;
    logic [7:0]  last_blank;
    logic        last_neg;
    logic        last_ovf;

    radix_digit_converter_if bus ();

    radix_digit_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Published results may only change on a done pulse or under reset.
    always @(negedge clk) begin
        if (bus.done) begin
            done_pulses = done_pulses + 1;
        end
        if (bus.done && bus.busy) begin
            overlap = overlap + 1;
        end
        if (rst || bus.done) begin
            last_digits = bus.digits;
            last_blank  = bus.blank;
            last_neg    = bus.neg;
            last_ovf    = bus.ovf;
        end else if (bus.digits !== last_digits || bus.blank !== last_blank ||
                     bus.neg !== last_neg || bus.ovf !== last_ovf) begin
            unstable = unstable + 1;
        end
    end

    function automatic void model(input logic [31:0] v, input logic [3:0] r,
                                  output logic [31:0] d, output logic [7:0] b,
                                  output logic n, output logic o);
        longint unsigned mag;
        longint unsigned base;
        longint unsigned p;
        longint unsigned low;
        base = (r == 4'd0) ? 64'd16 : {60'd0, r};
        mag  = v[31] ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        n    = v[31];
        d    = 32'd0;
        b    = 8'd0;
        p    = 64'd1;
        for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'((mag / p) % base);
            p = p * base;
        end
        o   = (mag >= p);
        low = mag % p;
        p   = 64'd1;
        for (int i = 0; i < 8; i++) begin
            b[i] = (i != 0) && (low < p);
            p = p * base;
        end
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses start and waits for done; extra start pulses can be injected at given edge numbers.
    task automatic apply_stimulus(input logic [31:0] v, input logic [3:0] r,
                                  input int inject_a, input int inject_b,
                                  output int latency, output logic busy_first);
        latency    = -1;
        busy_first = 1'b0;
        @(negedge clk);
        bus.value = v;
        bus.radix = r;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 300 && latency < 0; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 1) begin
                busy_first = bus.busy;
            end
            if (bus.done) begin
                latency = cyc - 1;
            end else if ((cyc - 1) == inject_a || (cyc - 1) == inject_b) begin
                bus.start = 1'b1;
                bus.value = 32'd99;
                bus.radix = 4'd0;
            end
        end
    endtask

    task automatic check_conversion(input string tag, input logic [31:0] v, input logic [3:0] r,
                                    input int inject_a, input int inject_b);
        int          latency;
        int          pulses_before;
        logic        busy_first;
        logic [31:0] exp_d;
        logic [7:0]  exp_b;
        logic        exp_n;
        logic        exp_o;
        pulses_before = done_pulses;
        model(v, r, exp_d, exp_b, exp_n, exp_o);
        apply_stimulus(v, r, inject_a, inject_b, latency, busy_first);
        check_output({tag, ".latency"}, latency, 32'd266);
        check_output({tag, ".busy"}, {31'd0, busy_first}, 32'd1);
        check_output({tag, ".digits"}, bus.digits, exp_d);
        check_output({tag, ".blank"}, {24'd0, bus.blank}, {24'd0, exp_b});
        check_output({tag, ".neg"}, {31'd0, bus.neg}, {31'd0, exp_n});
        check_output({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
        check_output({tag, ".valid"}, {31'd0, bus.valid}, 32'd1);
        @(negedge clk);
        check_output({tag, ".done_width"}, {31'd0, bus.done}, 32'd0);
        check_output({tag, ".pulses"}, done_pulses - pulses_before, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        check_output({tag, ".done"}, {31'd0, bus.done}, 32'd0);
        check_output({tag, ".valid"}, {31'd0, bus.valid}, 32'd0);
        check_output({tag, ".digits"}, bus.digits, 32'd0);
        check_output({tag, ".blank"}, {24'd0, bus.blank}, 32'hFE);
        check_output({tag, ".neg"}, {31'd0, bus.neg}, 32'd0);
        check_output({tag, ".ovf"}, {31'd0, bus.ovf}, 32'd0);
    endtask

    initial begin
        int pulses_before;
        total       = 0;
        bad         = 0;
        done_pulses = 0;
        unstable    = 0;
        overlap     = 0;
        last_digits = 32'd0;
        last_blank  = 8'hFE;
        last_neg    = 1'b0;
        last_ovf    = 1'b0;
        bus.start   = 1'b0;
        bus.value   = 32'd0;
        bus.radix   = 4'd0;
        rst         = 1'b1;
        $display("[TB] radix_digit_converter bench starting");

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        #2 rst = 1'b0;

        check_conversion("dec12345", 32'd12345, 4'd10, -1, -1);
        check_conversion("hex_m1", 32'hFFFF_FFFF, 4'd0, -1, -1);
        check_conversion("hex_min", 32'h8000_0000, 4'd0, -1, -1);
        check_conversion("dec_max", 32'h7FFF_FFFF, 4'd10, -1, -1);
        check_conversion("bin256", 32'd256, 4'd2, -1, -1);
        check_conversion("unary0", 32'd0, 4'd1, -1, -1);
        check_conversion("unary_neg", 32'hFFFF_FFF9, 4'd1, -1, -1);

        // Extra start pulses mid-conversion and in the DONE cycle must be dropped.
        pulses_before = done_pulses;
        check_conversion("ignore", 32'd255, 4'd0, 99, 265);
        repeat (300) @(negedge clk);
        check_output("ignore.total_pulses", done_pulses - pulses_before, 32'd1);
        check_output("ignore.idle", {31'd0, bus.busy}, 32'd0);

        @(negedge clk);
        bus.value = 32'd123456;
        bus.radix = 4'd10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (149) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("midreset");
        pulses_before = done_pulses;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (300) @(negedge clk);
        check_output("midreset.no_done", done_pulses - pulses_before, 32'd0);
        check_conversion("oct7", 32'd7, 4'd8, -1, -1);

        for (int code = 2; code <= 16; code++) begin
            check_conversion($sformatf("sweep%0d", code), 32'd100, 4'(code), -1, -1);
        end

        for (int k = 0; k < 12; k++) begin
            logic [31:0] rv;
            logic [3:0]  rr;
            rv = $urandom;
            if (k % 3 == 0) begin
                rv = rv >> $urandom_range(0, 31);
            end
            rr = 4'($urandom_range(0, 15));
            check_conversion($sformatf("rand%0d", k), rv, rr, -1, -1);
        end

        check_output("stable", unstable, 32'd0);
        check_output("busy_done_overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
